// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: sweeps a combinational ALU through all eight select codes.
// A start latches three operands. Each opcode is then held on the ALU for
// SETTLE_CYCLES clocks before its result is captured. The block streams
// (select, result) samples, keeps a running sum, and pulses done after the
// eighth sample.
module alu_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned START_SEL     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] c_in,
  input  logic [5:0] alu_out,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_c,
  output logic [2:0] alu_sel,
  output logic       busy,
  output logic       res_valid,
  output logic [2:0] res_sel,
  output logic [5:0] res_data,
  output logic [8:0] sum,
  output logic       done
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] FIRST_SEL   = 3'(START_SEL);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] settle_cnt_q;
  logic [2:0] op_cnt_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [3:0] alu_c_q;
  logic [2:0] alu_sel_q;
  logic       busy_q;
  logic       res_valid_q;
  logic [2:0] res_sel_q;
  logic [5:0] res_data_q;
  logic [8:0] sum_q;
  logic       done_q;

  logic       sample_hit;
  logic [8:0] sum_d;
  logic [3:0] settle_cnt_d;

  // Settle-window completion, the next settle count, and the accumulated sum if the current result is taken.
  always_comb begin
    sample_hit   = 1'b0;
    sum_d        = sum_q;
    settle_cnt_d = settle_cnt_q;
    if (settle_cnt_q == SETTLE_LAST) begin
      sample_hit   = 1'b1;
      settle_cnt_d = 4'd0;
    end else begin
      sample_hit   = 1'b0;
      settle_cnt_d = settle_cnt_q + 4'd1;
    end
    sum_d = sum_q + {3'b000, alu_out};
  end

  // Sweep sequencer: operand latch, settle timing, sample capture and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= 4'd0;
      op_cnt_q     <= 3'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_c_q      <= 4'd0;
      alu_sel_q    <= 3'd0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sel_q    <= 3'd0;
      res_data_q   <= 6'd0;
      sum_q        <= 9'd0;
      done_q       <= 1'b0;
    end else begin
      // Strobes are high for a single cycle only.
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            alu_a_q      <= a_in;
            alu_b_q      <= b_in;
            alu_c_q      <= c_in;
            alu_sel_q    <= FIRST_SEL;
            settle_cnt_q <= 4'd0;
            op_cnt_q     <= 3'd0;
            sum_q        <= 9'd0;
            busy_q       <= 1'b1;
            state_q      <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            // Cancel wins over a coinciding sample; partial results stay visible.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sample_hit) begin
            res_data_q   <= alu_out;
            res_sel_q    <= alu_sel_q;
            res_valid_q  <= 1'b1;
            sum_q        <= sum_d;
            alu_sel_q    <= alu_sel_q + 3'd1;
            op_cnt_q     <= op_cnt_q + 3'd1;
            settle_cnt_q <= settle_cnt_d;
            if (op_cnt_q == 3'd7) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SETTLE;
            end
          end else begin
            settle_cnt_q <= settle_cnt_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_sel   = alu_sel_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_sel   = res_sel_q;
  assign res_data  = res_data_q;
  assign sum       = sum_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl. Two instances cover (SETTLE=1, START=0) and
// (SETTLE=3, START=5). Each drives an ALU stub with out = a+b+c+sel. A
// timeline model predicts every output on every cycle. Literal
// expectations pin the sample sequences and the sums.
module tb_alu_sweep_ctrl;

  localparam int N0 = 1;
  localparam int S0 = 0;
  localparam int N1 = 3;
  localparam int S1 = 5;

  typedef struct {
    int sel;
    int data;
    int cyc;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2];
  logic       abort [2];
  logic [3:0] a_in [2];
  logic [3:0] b_in [2];
  logic [3:0] c_in [2];
  logic [5:0] alu_out [2];
  logic [3:0] alu_a [2];
  logic [3:0] alu_b [2];
  logic [3:0] alu_c [2];
  logic [2:0] alu_sel [2];
  logic       busy [2];
  logic       res_valid [2];
  logic [2:0] res_sel [2];
  logic [5:0] res_data [2];
  logic [8:0] sum [2];
  logic       done [2];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model state: elapsed edges since accept, latched operands, expected outputs.
  int m_el [2], m_a [2], m_b [2], m_c [2], m_sel [2], m_busy [2];
  int m_valid [2], m_rsel [2], m_rdata [2], m_sum [2], m_done [2];

  // Observations gathered by the monitor.
  samp_t q0[$];
  samp_t q1[$];
  int n_done [2];
  int n_busy [2];
  int last_done_cyc [2];

  alu_sweep_ctrl #(.SETTLE_CYCLES(N0), .START_SEL(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .a_in(a_in[0]), .b_in(b_in[0]), .c_in(c_in[0]), .alu_out(alu_out[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_c(alu_c[0]), .alu_sel(alu_sel[0]),
    .busy(busy[0]), .res_valid(res_valid[0]), .res_sel(res_sel[0]),
    .res_data(res_data[0]), .sum(sum[0]), .done(done[0])
  );

  alu_sweep_ctrl #(.SETTLE_CYCLES(N1), .START_SEL(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .a_in(a_in[1]), .b_in(b_in[1]), .c_in(c_in[1]), .alu_out(alu_out[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_c(alu_c[1]), .alu_sel(alu_sel[1]),
    .busy(busy[1]), .res_valid(res_valid[1]), .res_sel(res_sel[1]),
    .res_data(res_data[1]), .sum(sum[1]), .done(done[1])
  );

  assign alu_out[0] = {2'b00, alu_a[0]} + {2'b00, alu_b[0]} + {2'b00, alu_c[0]} + {3'b000, alu_sel[0]};
  assign alu_out[1] = {2'b00, alu_a[1]} + {2'b00, alu_b[1]} + {2'b00, alu_c[1]} + {3'b000, alu_sel[1]};

  always #5 clk = ~clk;

  // Edge counter used to time samples relative to the start-accept edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Timeline model: sample k (1..8) lands k*N edges after accept, with select (S+k-1) mod 8.
  always @(posedge clk or negedge rst_n) begin
    automatic int n, s, el, k, sel, d;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? N0 : N1;
      s = (i == 0) ? S0 : S1;
      if (!rst_n) begin
        m_el[i] <= 0; m_a[i] <= 0; m_b[i] <= 0; m_c[i] <= 0; m_sel[i] <= 0;
        m_busy[i] <= 0; m_valid[i] <= 0; m_rsel[i] <= 0; m_rdata[i] <= 0;
        m_sum[i] <= 0; m_done[i] <= 0;
      end else begin
        m_valid[i] <= 0;
        m_done[i]  <= 0;
        if (m_busy[i] != 0) begin
          if (abort[i]) begin
            m_busy[i] <= 0;
          end else begin
            el = m_el[i] + 1;
            m_el[i]  <= el;
            m_sel[i] <= (s + el / n) % 8;
            if (el % n == 0) begin
              k   = el / n;
              sel = (s + k - 1) % 8;
              d   = m_a[i] + m_b[i] + m_c[i] + sel;
              m_rsel[i]  <= sel;
              m_rdata[i] <= d;
              m_sum[i]   <= m_sum[i] + d;
              m_valid[i] <= 1;
              if (k == 8) begin
                m_busy[i] <= 0;
                m_done[i] <= 1;
              end
            end
          end
        end else if (start[i] && !abort[i]) begin
          m_a[i] <= int'(a_in[i]); m_b[i] <= int'(b_in[i]); m_c[i] <= int'(c_in[i]);
          m_sel[i] <= s; m_el[i] <= 0; m_sum[i] <= 0; m_busy[i] <= 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.alu_a", i),     int'(alu_a[i]),     m_a[i]);
      chk($sformatf("d%0d.alu_b", i),     int'(alu_b[i]),     m_b[i]);
      chk($sformatf("d%0d.alu_c", i),     int'(alu_c[i]),     m_c[i]);
      chk($sformatf("d%0d.alu_sel", i),   int'(alu_sel[i]),   m_sel[i]);
      chk($sformatf("d%0d.busy", i),      int'(busy[i]),      m_busy[i]);
      chk($sformatf("d%0d.res_valid", i), int'(res_valid[i]), m_valid[i]);
      chk($sformatf("d%0d.res_sel", i),   int'(res_sel[i]),   m_rsel[i]);
      chk($sformatf("d%0d.res_data", i),  int'(res_data[i]),  m_rdata[i]);
      chk($sformatf("d%0d.sum", i),       int'(sum[i]),       m_sum[i]);
      chk($sformatf("d%0d.done", i),      int'(done[i]),      m_done[i]);
    end
  end

  // Monitor: records samples, done pulses and busy cycles for the literal checks.
  always @(negedge clk) begin
    automatic samp_t smp;
    for (int i = 0; i < 2; i++) begin
      if (res_valid[i]) begin
        smp.sel  = int'(res_sel[i]);
        smp.data = int'(res_data[i]);
        smp.cyc  = cyc;
        if (i == 0) q0.push_back(smp);
        else q1.push_back(smp);
      end
      if (done[i]) begin
        n_done[i]        <= n_done[i] + 1;
        last_done_cyc[i] <= cyc;
      end
      if (busy[i]) n_busy[i] <= n_busy[i] + 1;
    end
  end

  function automatic samp_t qget(input int inst, input int idx);
    samp_t r;
    r.sel = -1; r.data = -1; r.cyc = -1;
    if (inst == 0) begin
      if (idx < q0.size()) r = q0[idx];
    end else begin
      if (idx < q1.size()) r = q1[idx];
    end
    return r;
  endfunction

  function automatic int qsize(input int inst);
    return (inst == 0) ? q0.size() : q1.size();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget);
    int nd0;
    int t;
    nd0 = n_done[i];
    t = 0;
    while (n_done[i] == nd0 && t < budget) begin
      tick(1);
      t++;
    end
    chk($sformatf("d%0d.done_within_budget", i), int'(n_done[i] != nd0), 1);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc, nd, bb, t;
    int exp_sel [8];
    samp_t s;
    exp_sel = '{5, 6, 7, 0, 1, 2, 3, 4};
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0;
      a_in[i] = 4'd0; b_in[i] = 4'd0; c_in[i] = 4'd0;
      n_done[i] = 0; n_busy[i] = 0; last_done_cyc[i] = 0;
    end

    // 1: reset for three cycles, then idle
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("t1.no_valid0", q0.size(), 0);
    chk("t1.no_valid1", q1.size(), 0);
    chk("t1.no_busy0", n_busy[0], 0);
    chk("t1.no_busy1", n_busy[1], 0);

    // 2: basic sweep on dut0
    base = q0.size(); bb = n_busy[0];
    a_in[0] = 4'd13; b_in[0] = 4'd12; c_in[0] = 4'd14; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0; acc = cyc;
    wait_done(0, 40);
    chk("t2.count", q0.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      s = qget(0, base + k);
      chk($sformatf("t2.sel%0d", k), s.sel, k);
      chk($sformatf("t2.data%0d", k), s.data, 39 + k);
      chk($sformatf("t2.lat%0d", k), s.cyc - acc, k + 1);
    end
    s = qget(0, base + 7);
    chk("t2.done_with_sel7", last_done_cyc[0], s.cyc);
    chk("t2.sum", int'(sum[0]), 340);
    chk("t2.model_sum", m_sum[0], 340);
    chk("t2.busy_cycles", n_busy[0] - bb, 8);
    tick(2);

    // 3: wrap and settle on dut1
    base = q1.size();
    a_in[1] = 4'd0; b_in[1] = 4'd0; c_in[1] = 4'd0; start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0; acc = cyc;
    wait_done(1, 60);
    for (int k = 0; k < 8; k++) begin
      s = qget(1, base + k);
      chk($sformatf("t3.sel%0d", k), s.sel, exp_sel[k]);
      chk($sformatf("t3.data%0d", k), s.data, exp_sel[k]);
      chk($sformatf("t3.spacing%0d", k), s.cyc - acc, 3 * (k + 1));
    end
    chk("t3.done_latency", last_done_cyc[1] - acc, 24);
    chk("t3.sum", int'(sum[1]), 28);
    chk("t3.model_sum", m_sum[1], 28);
    chk("t3.alu_sel_wrapped", int'(alu_sel[1]), 5);
    tick(2);

    // 4: abort after the third sample, then restart
    base = q0.size(); nd = n_done[0];
    a_in[0] = 4'd1; b_in[0] = 4'd2; c_in[0] = 4'd3; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    t = 0;
    while (q0.size() < base + 3 && t < 20) begin
      tick(1);
      t++;
    end
    chk("t4.three_samples", q0.size() - base, 3);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    chk("t4.busy_dropped", int'(busy[0]), 0);
    chk("t4.sum_held", int'(sum[0]), 21);
    chk("t4.model_sum", m_sum[0], 21);
    tick(10);
    chk("t4.no_more_samples", q0.size() - base, 3);
    chk("t4.no_done", n_done[0] - nd, 0);
    chk("t4.sum_still", int'(sum[0]), 21);
    chk("t4.res_data_held", int'(res_data[0]), 8);
    base = q0.size();
    a_in[0] = 4'd15; b_in[0] = 4'd15; c_in[0] = 4'd15; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    wait_done(0, 40);
    for (int k = 0; k < 8; k++) begin
      s = qget(0, base + k);
      chk($sformatf("t4.data%0d", k), s.data, 45 + k);
    end
    chk("t4.sum_restart", int'(sum[0]), 388);
    tick(2);

    // 5: start while busy, start on the done cycle, start one cycle later
    base = q0.size();
    a_in[0] = 4'd1; b_in[0] = 4'd1; c_in[0] = 4'd1; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(1);
    a_in[0] = 4'd7; b_in[0] = 4'd7; c_in[0] = 4'd7; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    chk("t5.alu_a_kept", int'(alu_a[0]), 1);
    tick(5);
    a_in[0] = 4'd2; b_in[0] = 4'd2; c_in[0] = 4'd2; start[0] = 1'b1;
    tick(1);
    chk("t5.done_pulse", int'(done[0]), 1);
    chk("t5.busy_after_done", int'(busy[0]), 0);
    tick(1);
    start[0] = 1'b0;
    chk("t5.restart_busy", int'(busy[0]), 1);
    chk("t5.alu_a_relatched", int'(alu_a[0]), 2);
    for (int k = 0; k < 8; k++) begin
      s = qget(0, base + k);
      chk($sformatf("t5.first_data%0d", k), s.data, 3 + k);
    end
    wait_done(0, 40);
    for (int k = 0; k < 8; k++) begin
      s = qget(0, base + 8 + k);
      chk($sformatf("t5.second_data%0d", k), s.data, 6 + k);
    end
    chk("t5.sum", int'(sum[0]), 76);
    tick(2);

    // 6: asynchronous reset during the fourth sample window of dut1
    base = q1.size(); nd = n_done[1];
    a_in[1] = 4'd1; b_in[1] = 4'd0; c_in[1] = 4'd0; start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    tick(10);
    chk("t6.pre_busy", int'(busy[1]), 1);
    chk("t6.pre_samples", q1.size() - base, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.alu_a", int'(alu_a[1]), 0);
    chk("t6.alu_b", int'(alu_b[1]), 0);
    chk("t6.alu_c", int'(alu_c[1]), 0);
    chk("t6.alu_sel", int'(alu_sel[1]), 0);
    chk("t6.busy", int'(busy[1]), 0);
    chk("t6.res_valid", int'(res_valid[1]), 0);
    chk("t6.res_sel", int'(res_sel[1]), 0);
    chk("t6.res_data", int'(res_data[1]), 0);
    chk("t6.sum", int'(sum[1]), 0);
    chk("t6.done", int'(done[1]), 0);
    chk("t6.dut0_alu_a", int'(alu_a[0]), 0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    chk("t6.no_done", n_done[1] - nd, 0);
    chk("t6.no_samples", qsize(1) - base, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
